// File: rtl/trig_pkg.sv
// Shared types and helpers for the trigger pulse path: FSM state encoding,
// default field widths and a saturating counter increment.
package trig_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        ACTIVE = 2'd2,
        DEAD   = 2'd3
    } state_t;

    localparam int unsigned DEF_DLY_W  = 8;
    localparam int unsigned DEF_WID_W  = 8;
    localparam int unsigned DEF_DEAD_W = 8;
    localparam int unsigned DEF_CNT_W  = 16;

    // Increment v, holding at the all-ones value of a w-bit field (w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] top;
        top = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v >= top) ? top : v + 32'd1;
    endfunction

endpackage

// File: rtl/trig_edge_sync.sv
// Two-flop synchroniser for an asynchronous discriminator level, followed by
// a history flop so a rising level yields a single-cycle rise strobe.
module trig_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic s1, s2, s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/trig_pulse_gen.sv
// Turns each rising edge of a raw discriminator level into one clock-aligned
// pulse with programmable delay, width and dead time; counts accepted/lost edges.
module trig_pulse_gen
    import trig_pkg::*;
#(
    parameter int unsigned DLY_W  = DEF_DLY_W,
    parameter int unsigned WID_W  = DEF_WID_W,
    parameter int unsigned DEAD_W = DEF_DEAD_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig_in,
    input  logic              enable,
    input  logic [DLY_W-1:0]  delay_cfg,
    input  logic [WID_W-1:0]  width_cfg,
    input  logic [DEAD_W-1:0] dead_cfg,
    output logic              pulse_out,
    output logic              busy,
    output logic [CNT_W-1:0]  trig_count,
    output logic [CNT_W-1:0]  lost_count
);

    // One down-counter serves all three timed phases, so it spans the widest field.
    localparam int unsigned CTR_W0 = (DLY_W > WID_W) ? DLY_W : WID_W;
    localparam int unsigned CTR_W  = (CTR_W0 > DEAD_W) ? CTR_W0 : DEAD_W;
    localparam logic [CTR_W-1:0] ONE = CTR_W'(1);

    function automatic logic [CTR_W-1:0] wid_load(input logic [WID_W-1:0] w);
        return (w == '0) ? ONE : CTR_W'(w);
    endfunction

    logic trig_edge;

    trig_edge_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (trig_in),
        .rise     (trig_edge)
    );

    state_t              state, state_n;
    logic [CTR_W-1:0]    ctr, ctr_n;
    logic [WID_W-1:0]    wid_r, wid_n;
    logic [DEAD_W-1:0]   dead_r, dead_n;
    logic                accept;
    logic                pulse_n, busy_n;
    logic [CNT_W-1:0]    trig_n, lost_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ctr        <= '0;
            wid_r      <= '0;
            dead_r     <= '0;
            pulse_out  <= 1'b0;
            busy       <= 1'b0;
            trig_count <= '0;
            lost_count <= '0;
        end else begin
            state      <= state_n;
            ctr        <= ctr_n;
            wid_r      <= wid_n;
            dead_r     <= dead_n;
            pulse_out  <= pulse_n;
            busy       <= busy_n;
            trig_count <= trig_n;
            lost_count <= lost_n;
        end
    end

    always_comb begin
        state_n = state;
        ctr_n   = ctr;
        wid_n   = wid_r;
        dead_n  = dead_r;
        accept  = 1'b0;
        unique case (state)
            IDLE: begin
                if (trig_edge && enable) begin
                    accept = 1'b1;
                    wid_n  = width_cfg;
                    dead_n = dead_cfg;
                    if (delay_cfg == '0) begin
                        state_n = ACTIVE;
                        ctr_n   = wid_load(width_cfg);
                    end else begin
                        state_n = DELAY;
                        ctr_n   = CTR_W'(delay_cfg);
                    end
                end
            end
            DELAY: begin
                if (ctr == ONE) begin
                    state_n = ACTIVE;
                    ctr_n   = wid_load(wid_r);
                end else begin
                    ctr_n = ctr - ONE;
                end
            end
            ACTIVE: begin
                if (ctr == ONE) begin
                    if (dead_r == '0) begin
                        state_n = IDLE;
                        ctr_n   = '0;
                    end else begin
                        state_n = DEAD;
                        ctr_n   = CTR_W'(dead_r);
                    end
                end else begin
                    ctr_n = ctr - ONE;
                end
            end
            DEAD: begin
                if (ctr == ONE) begin
                    state_n = IDLE;
                    ctr_n   = '0;
                end else begin
                    ctr_n = ctr - ONE;
                end
            end
            default: begin
                state_n = IDLE;
                ctr_n   = '0;
            end
        endcase
    end

    // Outputs are derived from the next state so they register alongside it.
    always_comb begin
        pulse_n = (state_n == ACTIVE);
        busy_n  = (state_n != IDLE);
        trig_n  = trig_count;
        lost_n  = lost_count;
        if (accept) begin
            trig_n = CNT_W'(sat_inc(32'(trig_count), CNT_W));
        end
        if (trig_edge && (state != IDLE)) begin
            lost_n = CNT_W'(sat_inc(32'(lost_count), CNT_W));
        end
    end

endmodule
